adc_trig_detect: RTL and testbench

//  Parametrised ADC acquisition trigger: boxcar moving average over 2^AVG_LOG2 samples, then a

---
 rtl/adc_trig_detect_if.sv | 29 ++
 rtl/adc_trig_detect.sv | 250 +++++++++++++++++++++++++
 tb/tb_adc_trig_detect.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_trig_detect_if.sv
// Sample stream, trigger control and trigger status of adc_trig_detect grouped as one bundle.
// The master side drives samples and trigger settings; the slave side is the detector.
interface adc_trig_detect_if #(
  parameter int DATA_W    = 16,
  parameter int HOLDOFF_W = 16
);
  logic [DATA_W-1:0]    ADC_Data;
  logic                 ADC_Conv_Done;
  logic                 Arm;
  logic                 Abort;
  logic [1:0]           Trig_Mode;
  logic [DATA_W-1:0]    Trig_Level;
  logic [DATA_W-1:0]    Trig_Hyst;
  logic [HOLDOFF_W-1:0] Holdoff;
  logic [DATA_W-1:0]    Avg_Data;
  logic                 Avg_Valid;
  logic                 Armed;
  logic                 Trig_Pulse;

  modport master (
    output ADC_Data, ADC_Conv_Done, Arm, Abort, Trig_Mode, Trig_Level, Trig_Hyst, Holdoff,
    input  Avg_Data, Avg_Valid, Armed, Trig_Pulse
  );

  modport slave (
    input  ADC_Data, ADC_Conv_Done, Arm, Abort, Trig_Mode, Trig_Level, Trig_Hyst, Holdoff,
    output Avg_Data, Avg_Valid, Armed, Trig_Pulse
  );
endinterface

// File: rtl/adc_trig_detect.sv
// ADC acquisition trigger: boxcar average over 2^AVG_LOG2 samples followed by a single-shot
// level-crossing trigger with hysteresis, edge selection, holdoff and abort.
module adc_trig_detect #(
  parameter int DATA_W    = 16,
  parameter int AVG_LOG2  = 3,
  parameter int HOLDOFF_W = 16
) (
  input logic               Clk,
  input logic               Rst,
  adc_trig_detect_if.slave  bus
);

  localparam int N      = 1 << AVG_LOG2;
  localparam int SUM_W  = DATA_W + AVG_LOG2;
  localparam int FILL_W = AVG_LOG2 + 1;

  localparam logic [1:0] MODE_RISE   = 2'b00;
  localparam logic [1:0] MODE_FALL   = 2'b01;
  localparam logic [1:0] MODE_EITHER = 2'b10;
  localparam logic [1:0] MODE_IMM    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HOLDOFF  = 3'd1,
    ST_SEEK     = 3'd2,
    ST_CROSS_UP = 3'd3,
    ST_CROSS_DN = 3'd4
  } state_t;

  function automatic logic [DATA_W-1:0] lo_thresh(input logic [DATA_W-1:0] level,
                                                  input logic [DATA_W-1:0] hyst);
    if (level > hyst) begin
      lo_thresh = level - hyst;
    end else begin
      lo_thresh = {DATA_W{1'b0}};
    end
  endfunction

  function automatic logic [DATA_W-1:0] hi_thresh(input logic [DATA_W-1:0] level,
                                                  input logic [DATA_W-1:0] hyst);
    logic [DATA_W:0] total;
    total = {1'b0, level} + {1'b0, hyst};
    if (total[DATA_W]) begin
      hi_thresh = {DATA_W{1'b1}};
    end else begin
      hi_thresh = total[DATA_W-1:0];
    end
  endfunction

  logic [DATA_W-1:0]    window_r [N];
  logic [SUM_W-1:0]     sum_r;
  logic [SUM_W-1:0]     sum_next_s;
  logic [FILL_W-1:0]    fill_r;
  logic                 full_next_s;
  logic [DATA_W-1:0]    avg_data_r;
  logic                 avg_valid_r;

  logic [1:0]           mode_r;
  logic [DATA_W-1:0]    level_r;
  logic [DATA_W-1:0]    lo_r;
  logic [DATA_W-1:0]    hi_r;
  logic [HOLDOFF_W-1:0] holdoff_r;

  state_t               state_r;
  state_t               state_next_s;
  logic [HOLDOFF_W-1:0] holdoff_cnt_r;
  logic [HOLDOFF_W-1:0] holdoff_cnt_next_s;
  logic                 fire_s;
  logic                 latch_s;
  logic                 armed_r;
  logic                 trig_pulse_r;

  // Running sum update; intermediate wrap cancels since the true sum always fits SUM_W.
  always_comb begin
    sum_next_s  = sum_r + SUM_W'(bus.ADC_Data) - SUM_W'(window_r[N-1]);
    full_next_s = (fill_r >= FILL_W'(N - 1));
  end

  // Sample window shift register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < N; i++) begin
        window_r[i] <= {DATA_W{1'b0}};
      end
    end else if (bus.ADC_Conv_Done) begin
      window_r[0] <= bus.ADC_Data;
      for (int i = 1; i < N; i++) begin
        window_r[i] <= window_r[i-1];
      end
    end
  end

  // Sum, fill count and the registered average outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      sum_r       <= {SUM_W{1'b0}};
      fill_r      <= {FILL_W{1'b0}};
      avg_data_r  <= {DATA_W{1'b0}};
      avg_valid_r <= 1'b0;
    end else if (bus.ADC_Conv_Done) begin
      sum_r       <= sum_next_s;
      if (fill_r != FILL_W'(N)) begin
        fill_r <= fill_r + FILL_W'(1);
      end
      avg_data_r  <= DATA_W'(sum_next_s >> AVG_LOG2);
      avg_valid_r <= full_next_s;
    end else begin
      avg_valid_r <= 1'b0;
    end
  end

  // Trigger settings captured when an Arm is accepted; thresholds are precomputed here.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      mode_r    <= MODE_RISE;
      level_r   <= {DATA_W{1'b0}};
      lo_r      <= {DATA_W{1'b0}};
      hi_r      <= {DATA_W{1'b0}};
      holdoff_r <= {HOLDOFF_W{1'b0}};
    end else if (latch_s) begin
      mode_r    <= bus.Trig_Mode;
      level_r   <= bus.Trig_Level;
      lo_r      <= lo_thresh(bus.Trig_Level, bus.Trig_Hyst);
      hi_r      <= hi_thresh(bus.Trig_Level, bus.Trig_Hyst);
      holdoff_r <= bus.Holdoff;
    end
  end

  // Trigger search next-state logic; Abort overrides every transition including a fire.
  always_comb begin
    state_next_s       = state_r;
    holdoff_cnt_next_s = holdoff_cnt_r;
    fire_s             = 1'b0;
    latch_s            = 1'b0;
    if (bus.Abort) begin
      state_next_s       = ST_IDLE;
      holdoff_cnt_next_s = {HOLDOFF_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.Arm) begin
            latch_s            = 1'b1;
            holdoff_cnt_next_s = {HOLDOFF_W{1'b0}};
            if (bus.Holdoff == {HOLDOFF_W{1'b0}}) begin
              state_next_s = ST_SEEK;
            end else begin
              state_next_s = ST_HOLDOFF;
            end
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_HOLDOFF: begin
          if (avg_valid_r) begin
            if ((holdoff_cnt_r + HOLDOFF_W'(1)) == holdoff_r) begin
              state_next_s       = ST_SEEK;
              holdoff_cnt_next_s = {HOLDOFF_W{1'b0}};
            end else begin
              holdoff_cnt_next_s = holdoff_cnt_r + HOLDOFF_W'(1);
            end
          end else begin
            state_next_s = ST_HOLDOFF;
          end
        end
        ST_SEEK: begin
          if (avg_valid_r) begin
            case (mode_r)
              MODE_RISE: begin
                if (avg_data_r <= lo_r) begin
                  state_next_s = ST_CROSS_UP;
                end else begin
                  state_next_s = ST_SEEK;
                end
              end
              MODE_FALL: begin
                if (avg_data_r >= hi_r) begin
                  state_next_s = ST_CROSS_DN;
                end else begin
                  state_next_s = ST_SEEK;
                end
              end
              MODE_EITHER: begin
                if (avg_data_r <= lo_r) begin
                  state_next_s = ST_CROSS_UP;
                end else if (avg_data_r >= hi_r) begin
                  state_next_s = ST_CROSS_DN;
                end else begin
                  state_next_s = ST_SEEK;
                end
              end
              MODE_IMM: begin
                fire_s       = 1'b1;
                state_next_s = ST_IDLE;
              end
              default: begin
                state_next_s = ST_IDLE;
              end
            endcase
          end else begin
            state_next_s = ST_SEEK;
          end
        end
        ST_CROSS_UP: begin
          if (avg_valid_r && (avg_data_r >= level_r)) begin
            fire_s       = 1'b1;
            state_next_s = ST_IDLE;
          end else if (avg_valid_r && (mode_r == MODE_EITHER) && (avg_data_r >= hi_r)) begin
            state_next_s = ST_CROSS_DN;
          end else begin
            state_next_s = ST_CROSS_UP;
          end
        end
        ST_CROSS_DN: begin
          if (avg_valid_r && (avg_data_r <= level_r)) begin
            fire_s       = 1'b1;
            state_next_s = ST_IDLE;
          end else if (avg_valid_r && (mode_r == MODE_EITHER) && (avg_data_r <= lo_r)) begin
            state_next_s = ST_CROSS_UP;
          end else begin
            state_next_s = ST_CROSS_DN;
          end
        end
        default: begin
          state_next_s = ST_IDLE;
        end
      endcase
    end
  end

  // State register with registered Armed and Trig_Pulse outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r       <= ST_IDLE;
      holdoff_cnt_r <= {HOLDOFF_W{1'b0}};
      armed_r       <= 1'b0;
      trig_pulse_r  <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      holdoff_cnt_r <= holdoff_cnt_next_s;
      armed_r       <= (state_next_s != ST_IDLE);
      trig_pulse_r  <= fire_s;
    end
  end

  assign bus.Avg_Data   = avg_data_r;
  assign bus.Avg_Valid  = avg_valid_r;
  assign bus.Armed      = armed_r;
  assign bus.Trig_Pulse = trig_pulse_r;

endmodule

// File: tb/tb_adc_trig_detect.sv
// Directed and randomized bench for adc_trig_detect (N=8); a sample-history model supplies
// expected averages and a rule scan over post-Arm averages supplies the expected trigger point.
module tb_adc_trig_detect;
  localparam int DATA_W    = 16;
  localparam int AVG_LOG2  = 3;
  localparam int HOLDOFF_W = 16;
  localparam int N         = 8;

  logic Clk = 1'b0;
  logic Rst;

  adc_trig_detect_if #(.DATA_W(DATA_W), .HOLDOFF_W(HOLDOFF_W)) bus ();

  adc_trig_detect #(.DATA_W(DATA_W), .AVG_LOG2(AVG_LOG2), .HOLDOFF_W(HOLDOFF_W)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  int tests_run    = 0;
  int tests_failed = 0;

  int q[$];
  int seq[$];
  bit m_armed = 1'b0;
  int m_mode, m_level, m_hyst, m_holdoff;
  logic [31:0] last_avg;
  logic        last_valid;
  logic        last_pulse;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_avg();
    int sum = 0;
    for (int k = 0; k < N; k++) begin
      if (k < q.size()) sum += q[q.size() - 1 - k];
    end
    return sum / N;
  endfunction

  // Index within seq at which the armed trigger should fire, or -1.
  function automatic int fire_index();
    int lo, hi, dir, a;
    lo  = (m_level > m_hyst) ? m_level - m_hyst : 0;
    hi  = (m_level + m_hyst > 65535) ? 65535 : m_level + m_hyst;
    dir = 0;
    for (int i = m_holdoff; i < seq.size(); i++) begin
      a = seq[i];
      if (m_mode == 3) return i;
      if (dir == 0) begin
        if ((m_mode == 0 || m_mode == 2) && a <= lo) dir = 1;
        else if ((m_mode == 1 || m_mode == 2) && a >= hi) dir = 2;
      end else if (dir == 1) begin
        if (a >= m_level) return i;
        else if (m_mode == 2 && a >= hi) dir = 2;
      end else begin
        if (a <= m_level) return i;
        else if (m_mode == 2 && a <= lo) dir = 1;
      end
    end
    return -1;
  endfunction

  task automatic send(input int sample, input bit abort_v = 1'b0);
    int exp_avg;
    bit exp_valid, exp_fire;
    bus.ADC_Data      = sample[15:0];
    bus.ADC_Conv_Done = 1'b1;
    q.push_back(sample);
    if (q.size() > N) void'(q.pop_front());
    exp_avg   = model_avg();
    exp_valid = (q.size() >= N);
    exp_fire  = 1'b0;
    if (exp_valid && m_armed) begin
      seq.push_back(exp_avg);
      if (fire_index() == seq.size() - 1) exp_fire = 1'b1;
    end
    if (abort_v) begin
      exp_fire = 1'b0;
      m_armed  = 1'b0;
    end
    if (exp_fire) m_armed = 1'b0;
    @(posedge Clk); #1;
    bus.ADC_Conv_Done = 1'b0;
    bus.Abort         = abort_v;
    last_avg   = 32'(bus.Avg_Data);
    last_valid = bus.Avg_Valid;
    check("avg_data", 32'(bus.Avg_Data), exp_avg);
    check("avg_valid", 32'(bus.Avg_Valid), 32'(exp_valid));
    @(posedge Clk); #1;
    bus.Abort  = 1'b0;
    last_pulse = bus.Trig_Pulse;
    check("trig_pulse", 32'(bus.Trig_Pulse), 32'(exp_fire));
    check("armed", 32'(bus.Armed), 32'(m_armed));
  endtask

  task automatic set_avg(input int target, input bit abort_v = 1'b0);
    int s = target * N;
    for (int k = 0; k < N - 1; k++) begin
      if (k < q.size()) s -= q[q.size() - 1 - k];
    end
    if (s < 0) s = 0;
    if (s > 65535) s = 65535;
    send(s, abort_v);
  endtask

  task automatic arm(input int mode, input int level, input int hyst, input int hold,
                     input bit with_abort = 1'b0);
    bus.Arm        = 1'b1;
    bus.Abort      = with_abort;
    bus.Trig_Mode  = mode[1:0];
    bus.Trig_Level = level[15:0];
    bus.Trig_Hyst  = hyst[15:0];
    bus.Holdoff    = hold[15:0];
    if (with_abort) begin
      m_armed = 1'b0;
    end else if (!m_armed) begin
      m_armed = 1'b1; m_mode = mode; m_level = level; m_hyst = hyst; m_holdoff = hold;
      seq.delete();
    end
    @(posedge Clk); #1;
    bus.Arm        = 1'b0;
    bus.Abort      = 1'b0;
    bus.Trig_Mode  = 2'($urandom);
    bus.Trig_Level = 16'($urandom);
    bus.Trig_Hyst  = 16'($urandom);
    bus.Holdoff    = 16'($urandom);
    check("armed_after_arm", 32'(bus.Armed), 32'(m_armed));
    check("no_pulse_on_arm", 32'(bus.Trig_Pulse), 32'd0);
  endtask

  task automatic abort_now();
    bus.Abort = 1'b1;
    m_armed   = 1'b0;
    @(posedge Clk); #1;
    bus.Abort = 1'b0;
    check("armed_after_abort", 32'(bus.Armed), 32'd0);
  endtask

  task automatic do_reset(input int cycles);
    Rst = 1'b1;
    repeat (cycles) @(posedge Clk);
    #1;
    check("rst_avg_data", 32'(bus.Avg_Data), 32'd0);
    check("rst_avg_valid", 32'(bus.Avg_Valid), 32'd0);
    check("rst_armed", 32'(bus.Armed), 32'd0);
    check("rst_trig_pulse", 32'(bus.Trig_Pulse), 32'd0);
    Rst = 1'b0;
    q.delete();
    seq.delete();
    m_armed = 1'b0;
  endtask

  initial begin
    bus.ADC_Data = 16'd0; bus.ADC_Conv_Done = 1'b0; bus.Arm = 1'b0; bus.Abort = 1'b0;
    bus.Trig_Mode = 2'b00; bus.Trig_Level = 16'd0; bus.Trig_Hyst = 16'd0; bus.Holdoff = 16'd0;
    Rst = 1'b1;
    @(posedge Clk); #1;
    do_reset(2);

    // T2: averaging and fill
    for (int k = 0; k < N; k++) send(1000);
    check("t2_first_avg", last_avg, 32'd1000);
    check("t2_first_valid", 32'(last_valid), 32'd1);
    for (int k = 1; k <= N; k++) begin
      send(2000);
      check("t2_step_avg", last_avg, 32'(1000 + 125 * k));
    end

    // T3: rising with hysteresis
    for (int k = 0; k < N; k++) send(1050);
    arm(0, 1000, 100, 0);
    set_avg(1050); set_avg(950); set_avg(1000);
    check("t3_no_pulse_above_lo", 32'(last_pulse), 32'd0);
    set_avg(880); set_avg(1000);
    check("t3_pulse", 32'(last_pulse), 32'd1);

    // T4: falling, then LO clamped at 0
    for (int k = 0; k < N; k++) send(1100);
    arm(1, 1000, 100, 0);
    set_avg(1100); set_avg(1000);
    check("t4_fall_pulse", 32'(last_pulse), 32'd1);
    for (int k = 0; k < N; k++) send(0);
    arm(0, 50, 100, 0);
    set_avg(10); set_avg(60);
    check("t4_lo_clamp_no_pulse", 32'(last_pulse), 32'd0);
    for (int k = 0; k < N; k++) send(0);
    set_avg(50);
    check("t4_lo_clamp_pulse", 32'(last_pulse), 32'd1);

    // T5: holdoff of 3 valid averages
    for (int k = 0; k < N; k++) send(1000);
    arm(0, 1000, 100, 3);
    set_avg(880); set_avg(1000);
    check("t5_holdoff_no_pulse", 32'(last_pulse), 32'd0);
    set_avg(880);
    check("t5_holdoff_armed", 32'(bus.Armed), 32'd1);
    set_avg(880); set_avg(1000);
    check("t5_pulse_after_holdoff", 32'(last_pulse), 32'd1);

    // T6: abort beats fire, Arm while armed ignored, Arm+Abort in idle, immediate mode
    for (int k = 0; k < N; k++) send(1000);
    arm(0, 1000, 100, 0);
    set_avg(880); set_avg(1000, 1'b1);
    check("t6_abort_no_pulse", 32'(last_pulse), 32'd0);
    check("t6_abort_disarmed", 32'(bus.Armed), 32'd0);
    arm(0, 1000, 100, 0, 1'b1);
    arm(0, 1000, 100, 0);
    arm(1, 5000, 10, 2);
    set_avg(880); set_avg(1000);
    check("t6_rearm_ignored_pulse", 32'(last_pulse), 32'd1);
    arm(3, 0, 0, 0);
    set_avg(1234);
    check("t6_immediate_pulse", 32'(last_pulse), 32'd1);

    // T1: reset mid-search empties the window
    arm(0, 1000, 100, 0);
    send(1500); send(700);
    do_reset(3);
    for (int k = 0; k < N - 1; k++) begin
      send(1000);
      check("t1_no_valid", 32'(last_valid), 32'd0);
    end
    send(1000);
    check("t1_valid_8th", 32'(last_valid), 32'd1);

    // Randomized rounds against the model
    for (int r = 0; r < 40; r++) begin
      arm($urandom_range(0, 3), $urandom_range(1500, 2500), $urandom_range(0, 600),
          $urandom_range(0, 3));
      for (int k = 0; k < 14; k++) begin
        if (m_armed && $urandom_range(0, 19) == 0)
          arm($urandom_range(0, 3), $urandom_range(0, 4000), $urandom_range(0, 600), 0);
        send($urandom_range(0, 4000), ($urandom_range(0, 24) == 0));
      end
      if (m_armed) abort_now();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
